wb_stage_pipe: RTL and testbench

Parametrised writeback stage for the ARM pipeline. It replaces the plain ALU/memory result select with four functions:
- MEM/WB pipeline register with valid/ready handshake.
- Three-way result select: ALU, load data, or link (PC+4).
- Byte/halfword load extraction with sign or zero extension, and a rotate for unaligned word loads.
- Wait state for slow memory, with a bounded timeout.
It sits between the MEM stage and the register file. It drives the register-file write port and the forwarding unit.

---
 rtl/wb_stage_pipe.sv | 139 +++++++++++++
 tb/tb_wb_stage_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB register with handshake, result select, load
// extraction (byte/halfword/rotated word) and a bounded wait for slow memory.
module wb_stage_pipe #(
  parameter  int unsigned DATA_LEN     = 32,
  parameter  int unsigned REG_ADDR_LEN = 4,
  parameter  int unsigned WAIT_LIMIT   = 15,
  localparam int unsigned LANE_LEN     = $clog2(DATA_LEN / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_wb_en,
  input  logic [REG_ADDR_LEN-1:0] in_dest,
  input  logic                    in_mem_r_en,
  input  logic                    in_link,
  input  logic [1:0]              in_size,
  input  logic                    in_signed,
  input  logic [LANE_LEN-1:0]     in_addr_lo,
  input  logic [DATA_LEN-1:0]     alu_res,
  input  logic [DATA_LEN-1:0]     pc_plus4,
  input  logic [DATA_LEN-1:0]     mem_out,
  input  logic                    mem_ready,
  output logic                    wb_valid,
  output logic                    wb_en,
  output logic [REG_ADDR_LEN-1:0] wb_dest,
  output logic [DATA_LEN-1:0]     wb_value,
  output logic                    wb_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state;
  logic [7:0]              wait_cnt;
  logic [REG_ADDR_LEN-1:0] cap_dest;
  logic                    cap_wb_en;
  logic [1:0]              cap_size;
  logic                    cap_signed;
  logic [LANE_LEN-1:0]     cap_addr_lo;
  logic [DATA_LEN-1:0]     in_result;

  assign in_ready = (state == IDLE);

  function automatic logic [DATA_LEN-1:0] extract(
    input logic [DATA_LEN-1:0] data,
    input logic [1:0]          size,
    input logic                sgn,
    input logic [LANE_LEN-1:0] lo
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [2*DATA_LEN-1:0] dbl;
    logic [DATA_LEN-1:0]   res;
    b   = 8'(data >> {lo, 3'b000});
    h   = 16'(data >> {lo[LANE_LEN-1:1], 4'b0000});
    // Unaligned word loads rotate right by the byte offset.
    dbl = {data, data} >> {lo, 3'b000};
    case (size)
      2'b01:   res = sgn ? {{(DATA_LEN-8){b[7]}}, b} : {{(DATA_LEN-8){1'b0}}, b};
      2'b10:   res = sgn ? {{(DATA_LEN-16){h[15]}}, h} : {{(DATA_LEN-16){1'b0}}, h};
      default: res = dbl[DATA_LEN-1:0];
    endcase
    return res;
  endfunction

  always_comb begin
    in_result = alu_res;
    if (in_link)
      in_result = pc_plus4;
    else if (in_mem_r_en)
      in_result = extract(mem_out, in_size, in_signed, in_addr_lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_dest     <= '0;
      wb_value    <= '0;
      wb_err      <= 1'b0;
      cap_dest    <= '0;
      cap_wb_en   <= 1'b0;
      cap_size    <= '0;
      cap_signed  <= 1'b0;
      cap_addr_lo <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_err   <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        wait_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              // A link result never depends on memory, so only true loads wait.
              if (in_mem_r_en && !in_link && !mem_ready) begin
                state       <= WAIT;
                wait_cnt    <= '0;
                cap_dest    <= in_dest;
                cap_wb_en   <= in_wb_en;
                cap_size    <= in_size;
                cap_signed  <= in_signed;
                cap_addr_lo <= in_addr_lo;
              end else begin
                wb_valid <= 1'b1;
                wb_en    <= in_wb_en;
                wb_dest  <= in_dest;
                wb_value <= in_result;
              end
            end
          end
          WAIT: begin
            if (mem_ready) begin
              state    <= IDLE;
              wait_cnt <= '0;
              wb_valid <= 1'b1;
              wb_en    <= cap_wb_en;
              wb_dest  <= cap_dest;
              wb_value <= extract(mem_out, cap_size, cap_signed, cap_addr_lo);
            end else if (wait_cnt == 8'(WAIT_LIMIT - 1)) begin
              state    <= IDLE;
              wait_cnt <= '0;
              wb_err   <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe; each task drives one scenario and checks inline.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en;
  logic [3:0]  in_dest;
  logic        in_mem_r_en;
  logic        in_link;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [1:0]  in_addr_lo;
  logic [31:0] alu_res;
  logic [31:0] pc_plus4;
  logic [31:0] mem_out;
  logic        mem_ready;
  logic        wb_valid;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.DATA_LEN(32), .REG_ADDR_LEN(4), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_dest(in_dest), .in_mem_r_en(in_mem_r_en), .in_link(in_link),
    .in_size(in_size), .in_signed(in_signed), .in_addr_lo(in_addr_lo), .alu_res(alu_res),
    .pc_plus4(pc_plus4), .mem_out(mem_out), .mem_ready(mem_ready), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .wb_err(wb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_wb_en = 0; in_dest = 0; in_mem_r_en = 0; in_link = 0;
    in_size = 0; in_signed = 0; in_addr_lo = 0; alu_res = 0; pc_plus4 = 0; mem_out = 0;
    mem_ready = 0;
  endtask

  task automatic start_load(input logic [3:0] dest, input logic [1:0] size,
                            input logic sgn, input logic [1:0] lo);
    in_valid = 1; in_mem_r_en = 1; in_wb_en = 1; in_dest = dest;
    in_size = size; in_signed = sgn; in_addr_lo = lo;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if ({wb_valid, wb_en, wb_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {wb_valid, wb_en, wb_err}); end
    checks++; if ({wb_dest, wb_value} !== 36'h0) begin errors++; $display("FAIL reset_data got %h want 0", {wb_dest, wb_value}); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu();
    in_valid = 1; in_wb_en = 1; in_dest = 3; alu_res = 32'h12345678; pc_plus4 = 32'h55;
    tick();
    idle_inputs();
    checks++; if ({wb_valid, wb_en} !== 2'b11) begin errors++; $display("FAIL alu_flags got %b want 11", {wb_valid, wb_en}); end
    checks++; if (wb_dest !== 4'd3) begin errors++; $display("FAIL alu_dest got %0d want 3", wb_dest); end
    checks++; if (wb_value !== 32'h12345678) begin errors++; $display("FAIL alu_value got %h want 12345678", wb_value); end
    tick();
    checks++; if ({wb_valid, wb_en} !== 2'b00) begin errors++; $display("FAIL alu_idle_flags got %b want 00", {wb_valid, wb_en}); end
    checks++; if (wb_value !== 32'h12345678) begin errors++; $display("FAIL alu_hold_value got %h want 12345678", wb_value); end
  endtask

  task automatic test_byte_load();
    start_load(4'd7, 2'b01, 1'b1, 2'd3); mem_out = 32'h80FF7F01; mem_ready = 1; alu_res = 32'hDEAD;
    tick();
    checks++; if (wb_value !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed got %h want ffffff80", wb_value); end
    checks++; if ({wb_valid, wb_en, wb_dest} !== {2'b11, 4'd7}) begin errors++; $display("FAIL byte_ctrl got %b want 110111", {wb_valid, wb_en, wb_dest}); end
    in_signed = 0;
    tick();
    checks++; if (wb_value !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned got %h want 00000080", wb_value); end
    in_signed = 1; in_addr_lo = 2'd2;
    tick();
    checks++; if (wb_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL byte_lane2 got %h want ffffffff", wb_value); end
    idle_inputs();
  endtask

  task automatic test_half_rotate();
    start_load(4'd1, 2'b10, 1'b0, 2'd2); mem_out = 32'hBEEF1234; mem_ready = 1;
    tick();
    checks++; if (wb_value !== 32'h0000BEEF) begin errors++; $display("FAIL half_unsigned got %h want 0000beef", wb_value); end
    in_signed = 1; in_addr_lo = 2'd1;
    tick();
    checks++; if (wb_value !== 32'h00001234) begin errors++; $display("FAIL half_low_lane got %h want 00001234", wb_value); end
    in_addr_lo = 2'd3;
    tick();
    checks++; if (wb_value !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_signed got %h want ffffbeef", wb_value); end
    in_size = 2'b00; in_addr_lo = 2'd1; mem_out = 32'h11223344;
    tick();
    checks++; if (wb_value !== 32'h44112233) begin errors++; $display("FAIL rotate_1 got %h want 44112233", wb_value); end
    in_addr_lo = 2'd0;
    tick();
    checks++; if (wb_value !== 32'h11223344) begin errors++; $display("FAIL rotate_0 got %h want 11223344", wb_value); end
    in_size = 2'b11; in_addr_lo = 2'd3;
    tick();
    checks++; if (wb_value !== 32'h22334411) begin errors++; $display("FAIL size11_rotate got %h want 22334411", wb_value); end
    idle_inputs();
    tick();
  endtask

  task automatic test_slow_mem();
    start_load(4'd9, 2'b00, 1'b0, 2'd0); mem_out = 32'h0BADBEEF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL slow_accept_ready got %b want 1", in_ready); end
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL slow_wait_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL slow_wait_valid[%0d] got %b want 0", i, wb_valid); end
      if (i == 2) begin mem_ready = 1; mem_out = 32'hCAFEF00D; end
      tick();
    end
    idle_inputs();
    checks++; if ({wb_valid, wb_en, wb_dest} !== {2'b11, 4'd9}) begin errors++; $display("FAIL slow_ctrl got %b want 111001", {wb_valid, wb_en, wb_dest}); end
    checks++; if (wb_value !== 32'hCAFEF00D) begin errors++; $display("FAIL slow_value got %h want cafef00d", wb_value); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL slow_ready_back got %b want 1", in_ready); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL slow_valid_once got %b want 0", wb_valid); end
  endtask

  task automatic test_timeout();
    start_load(4'd2, 2'b00, 1'b0, 2'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({wb_err, wb_en, in_ready} !== 3'b000) begin errors++; $display("FAIL timeout_wait[%0d] got %b want 000", i, {wb_err, wb_en, in_ready}); end
    end
    tick();
    checks++; if ({wb_err, wb_valid, wb_en} !== 3'b100) begin errors++; $display("FAIL timeout_err got %b want 100", {wb_err, wb_valid, wb_en}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle got %b want 1", in_ready); end
    tick();
    checks++; if ({wb_err, wb_en} !== 2'b00) begin errors++; $display("FAIL timeout_pulse got %b want 00", {wb_err, wb_en}); end
    // mem_ready arriving on the limit cycle wins over the timeout
    start_load(4'd4, 2'b00, 1'b0, 2'd0);
    tick();
    idle_inputs();
    tick(); tick(); tick();
    mem_ready = 1; mem_out = 32'h600D600D;
    tick();
    idle_inputs();
    checks++; if ({wb_err, wb_valid, wb_en} !== 3'b011) begin errors++; $display("FAIL limit_tie got %b want 011", {wb_err, wb_valid, wb_en}); end
    checks++; if (wb_value !== 32'h600D600D) begin errors++; $display("FAIL limit_tie_value got %h want 600d600d", wb_value); end
    tick();
  endtask

  task automatic test_link_nowb();
    in_valid = 1; in_link = 1; in_wb_en = 1; in_dest = 14; pc_plus4 = 32'h104; alu_res = 32'h999;
    tick();
    checks++; if (wb_value !== 32'h104) begin errors++; $display("FAIL link_value got %h want 00000104", wb_value); end
    checks++; if (wb_dest !== 4'd14) begin errors++; $display("FAIL link_dest got %0d want 14", wb_dest); end
    idle_inputs();
    in_valid = 1; in_wb_en = 0; alu_res = 32'h77;
    tick();
    idle_inputs();
    checks++; if ({wb_valid, wb_en} !== 2'b10) begin errors++; $display("FAIL no_wb_en got %b want 10", {wb_valid, wb_en}); end
    checks++; if (wb_value !== 32'h77) begin errors++; $display("FAIL no_wb_value got %h want 00000077", wb_value); end
    tick();
  endtask

  task automatic test_flush();
    start_load(4'd6, 2'b00, 1'b0, 2'd0);
    tick();
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
    checks++; if ({in_ready, wb_valid, wb_en, wb_err} !== 4'b1000) begin errors++; $display("FAIL flush_wait got %b want 1000", {in_ready, wb_valid, wb_en, wb_err}); end
    mem_ready = 1; mem_out = 32'h1111;
    tick();
    checks++; if ({wb_valid, wb_en, wb_err} !== 3'b000) begin errors++; $display("FAIL flush_late_mem got %b want 000", {wb_valid, wb_en, wb_err}); end
    idle_inputs();
    in_valid = 1; in_wb_en = 1; alu_res = 32'hABCD; flush = 1;
    tick();
    idle_inputs();
    checks++; if ({wb_valid, wb_en} !== 2'b00) begin errors++; $display("FAIL flush_accept got %b want 00", {wb_valid, wb_en}); end
    checks++; if (wb_value !== 32'h77) begin errors++; $display("FAIL flush_hold got %h want 00000077", wb_value); end
  endtask

  task automatic test_reset_mid_wait();
    start_load(4'd8, 2'b00, 1'b0, 2'd0);
    tick();
    idle_inputs();
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready got %b want 1", in_ready); end
    checks++; if ({wb_valid, wb_en, wb_err, wb_dest, wb_value} !== 39'h0) begin errors++; $display("FAIL rst_wait_outputs got %h want 0", {wb_valid, wb_en, wb_err, wb_dest, wb_value}); end
    tick();
    rst_n = 1;
    mem_ready = 1; mem_out = 32'h2222;
    tick();
    checks++; if ({wb_valid, wb_en} !== 2'b00) begin errors++; $display("FAIL rst_no_write got %b want 00", {wb_valid, wb_en}); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_byte_load();
    test_half_rotate();
    test_slow_mem();
    test_timeout();
    test_link_nowb();
    test_flush();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
